audio_out_arbiter: RTL

Shares the single codec output path (the Audio_Controller write port) between the game tone mix from the DJ mixer and the stone/loss effect. It paces writes at the codec sample rate and selects or mixes the two sources per sample. It runs the write handshake against `audio_out_allowed` and counts samples dropped when the codec FIFO stalls. It sits between the DJ mixer, play_stone and Audio_Controller, and replaces the ad-hoc `write_audio_out` expression.

---
 rtl/audio_out_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/audio_out_arbiter.sv
// Purpose: shares the codec write port between the tone mix and the stone effect, one sample per SAMPLE_DIV cycles.
// Latency: tick at T -> sample latched at T+1 -> write strobe at T+3 when the codec FIFO accepts immediately.
// Backpressure: waits on audio_out_allowed; a tick while still waiting drops the pending sample and relatches.
//
// Ports:
//   clock              system clock (CLOCK_50)
//   resetn             synchronous reset, active high (1 = reset)
//   tone_req/_sample   tone source request and signed 32-bit sample
//   stone_req/_sample  stone effect request and signed 32-bit sample
//   mute               suppresses the tone source only
//   audio_out_allowed  codec FIFO has space
//   left_out/right_out sample to codec (identical)
//   write_audio_out    one-cycle write strobe
//   grant              00 silence, 01 tone, 10 stone, 11 mix
//   underrun           one-cycle pulse per dropped sample
//   drop_count         saturating count of dropped samples
module audio_out_arbiter #(
  parameter int unsigned SAMPLE_DIV = 1042
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        tone_req,
  input  logic [31:0] tone_sample,
  input  logic        stone_req,
  input  logic [31:0] stone_sample,
  input  logic        mute,
  input  logic        audio_out_allowed,
  output logic [31:0] left_out,
  output logic [31:0] right_out,
  output logic        write_audio_out,
  output logic [1:0]  grant,
  output logic        underrun,
  output logic [7:0]  drop_count
);

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LATCH      = 2'd1,
    WAIT_ALLOW = 2'd2,
    WRITE      = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] div_cnt;
  logic        tick;
  logic        tone_eff;
  logic [31:0] sel_sample;
  logic [1:0]  sel_grant;
  logic signed [31:0] tone_half;
  logic signed [31:0] stone_half;

  assign tick     = (div_cnt == DIV_LAST);
  assign tone_eff = tone_req & ~mute;

  // Halving each operand before the add keeps the sum inside 32 bits.
  assign tone_half  = $signed(tone_sample) >>> 1;
  assign stone_half = $signed(stone_sample) >>> 1;

  always_comb begin
    sel_sample = 32'd0;
    sel_grant  = 2'b00;
    case ({stone_req, tone_eff})
      2'b01: begin
        sel_sample = tone_sample;
        sel_grant  = 2'b01;
      end
      2'b10: begin
        sel_sample = stone_sample;
        sel_grant  = 2'b10;
      end
      2'b11: begin
        sel_sample = 32'(tone_half + stone_half);
        sel_grant  = 2'b11;
      end
      default: begin
        sel_sample = 32'd0;
        sel_grant  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state           <= IDLE;
      div_cnt         <= 16'd0;
      left_out        <= 32'd0;
      right_out       <= 32'd0;
      grant           <= 2'b00;
      write_audio_out <= 1'b0;
      underrun        <= 1'b0;
      drop_count      <= 8'd0;
    end else begin
      // Sample pacing is independent of the handshake so the rate never drifts.
      div_cnt         <= tick ? 16'd0 : div_cnt + 16'd1;
      write_audio_out <= 1'b0;
      underrun        <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) state <= LATCH;
        end
        LATCH: begin
          left_out  <= sel_sample;
          right_out <= sel_sample;
          grant     <= sel_grant;
          state     <= WAIT_ALLOW;
        end
        WAIT_ALLOW: begin
          // A write accepted on the tick cycle wins; that tick is simply consumed.
          if (audio_out_allowed) begin
            write_audio_out <= 1'b1;
            state           <= WRITE;
          end else if (tick) begin
            underrun <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            state <= LATCH;
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
